// File: rtl/and3_test_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : and3_test_sequencer_pkg
// Brief  : Shared state encoding and truth-table constants for the AND3 self-test.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package and3_test_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    localparam logic [7:0] AND3_TT  = 8'h80;
    localparam logic [2:0] VEC_LAST = 3'd7;

endpackage

`default_nettype wire

// File: rtl/and3_test_sequencer_hold_timer.sv
//------------------------------------------------------------------------------
// Module : hold_timer
// Brief  : Cycle counter flagging the last cycle a test vector is held.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hold_timer #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = en && (r_cnt == WIDTH'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/and3_test_sequencer.sv
//------------------------------------------------------------------------------
// Module : and3_test_sequencer
// Brief  : Sweeps all eight {a,b,c} vectors into an AND3 gate and scores y.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module and3_test_sequencer
    import and3_test_sequencer_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] EXPECT      = AND3_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec
);

    localparam int C_TW = $clog2(HOLD_CYCLES + 1);

    seq_state_t r_state;
    logic [2:0] r_vec;
    logic       w_expired;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    hold_timer #(
        .WIDTH    (C_TW),
        .TERMINAL (HOLD_CYCLES - 1)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((r_state == S_IDLE) || (r_state == S_SAMPLE)),
        .en      (r_state == S_APPLY),
        .expired (w_expired)
    );

    assign w_mismatch = (y != EXPECT[r_vec]);
    assign w_err_next = err_count + {3'd0, w_mismatch};

    // Gate inputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vec     <= 3'd0;
            {a, b, c} <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    {a, b, c} <= 3'd0;
                    busy      <= 1'b0;
                    if (start) begin
                        r_vec     <= 3'd0;
                        err_count <= 4'd0;
                        fail_vec  <= 3'd0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (w_expired) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        err_count <= w_err_next;
                        if (err_count == 4'd0) begin
                            fail_vec <= r_vec;
                        end
                    end
                    if (r_vec == VEC_LAST) begin
                        {a, b, c} <= 3'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (w_err_next == 4'd0);
                        r_state   <= S_DONE;
                    end else begin
                        r_vec     <= r_vec + 3'd1;
                        {a, b, c} <= r_vec + 3'd1;
                        r_state   <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_and3_test_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_and3_test_sequencer
// Brief  : Self-checking bench for and3_test_sequencer with a behavioural gate.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_and3_test_sequencer;

    localparam int HOLD  = 4;
    localparam int SWEEP = 8 * (HOLD + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] fail_vec;

    logic       use_tt = 1'b0;
    logic [7:0] gate_tt = 8'h00;

    int n_err = 0;
    int n_chk = 0;

    // Good gate is a plain AND; faulty gates come from an arbitrary truth table.
    assign y = use_tt ? gate_tt[{a, b, c}] : (a & b & c);

    always #5 clk = ~clk;

    and3_test_sequencer #(
        .HOLD_CYCLES (HOLD),
        .EXPECT      (8'h80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y         (y),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected score: vector v should produce 1 only when a=b=c=1 (v==7).
    function automatic void score(input logic [7:0] tt, output int e, output int fv);
        e  = 0;
        fv = 0;
        for (int v = 7; v >= 0; v--) begin
            if (tt[v] != (v == 7)) begin
                e++;
                fv = v;
            end
        end
    endfunction

    task automatic run_sweep(input bit faulty, input logic [7:0] tt, input bit poke);
        int e, fv;
        score(faulty ? tt : 8'h80, e, fv);
        use_tt  = faulty;
        gate_tt = tt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < SWEEP; n++) begin
            check("abc", {29'd0, a, b, c}, n / (HOLD + 1));
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (poke) start = (n == 2 * (HOLD + 1) + 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("abc_end", {29'd0, a, b, c}, 0);
        check("pass", pass, (e == 0));
        check("err_count", err_count, e);
        check("fail_vec", fail_vec, fv);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("err_hold", err_count, e);
        check("pass_hold", pass, (e == 0));
    endtask

    initial begin
        int t;
        int held_err;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fv", fail_vec, 0);
        check("rst_abc", {29'd0, a, b, c}, 0);

        run_sweep(1'b0, 8'h00, 1'b0);          // good gate
        run_sweep(1'b1, 8'h00, 1'b0);          // stuck-at-0
        run_sweep(1'b1, 8'hFF, 1'b0);          // stuck-at-1

        // Reset in the middle of vector 4 aborts the sweep.
        use_tt = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * (HOLD + 1) + 2) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_abc", {29'd0, a, b, c}, 0);
        check("abort_err", err_count, 0);
        check("abort_pass", pass, 0);
        repeat (3) @(negedge clk);
        check("abort_idle", busy, 0);
        run_sweep(1'b0, 8'h00, 1'b0);

        run_sweep(1'b0, 8'h00, 1'b1);          // start re-pulsed while busy

        // Randomized faulty gates and idle gaps.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(1'b1, 8'($urandom), 1'b0);
        end

        // start held high: back-to-back sweeps every 42 cycles.
        use_tt  = 1'b1;
        gate_tt = 8'h81;
        @(negedge clk);
        start = 1'b1;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("held_first", done, 1);
        held_err = err_count;
        check("held_err", held_err, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t = 1;
            check("held_between", err_count, held_err);
            check("held_pass_between", pass, 0);
            while (!done && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("held_period", t, SWEEP + 2);
            check("held_fv", fail_vec, 0);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("held_stop", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
